// File: rtl/var_clk_seq_pkg.sv
// Shared types and default widths for the multi-channel variable tempo sequencer.
package var_clk_seq_pkg;

  localparam int CHANNELS_DEF = 4;
  localparam int PERIOD_W_DEF = 10;
  localparam int STEP_W_DEF   = 4;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } chan_state_e;

endpackage

// File: rtl/var_clk_chan.sv
// One tempo channel: half-period counter, square wave and step sequencer.
module var_clk_chan
  import var_clk_seq_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int STEP_W   = STEP_W_DEF
) (
  input  logic                clk100hz,
  input  logic                rst,
  input  logic                enable,
  input  logic                restart,
  input  logic [PERIOD_W-1:0] period,
  input  logic [STEP_W-1:0]   step_len,
  output logic                tick,
  output logic                clk_out,
  output logic                wrap,
  output logic [STEP_W-1:0]   step
);

  chan_state_e         state_s;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] ap_q, ap_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [STEP_W-1:0]   last_step_s;
  logic                clk_q, clk_d;
  logic                tick_q, tick_d;
  logic                wrap_q, wrap_d;

  // The channel state follows enable and the held active period each cycle.
  always_comb begin
    state_s = STOP;
    if (!enable) begin
      state_s = STOP;
    end else if (ap_q == {PERIOD_W{1'b0}}) begin
      state_s = HALT;
    end else begin
      state_s = RUN;
    end
  end

  // A step_len of zero selects the full 2^STEP_W sequence, whose last index is all ones.
  always_comb begin
    if (step_len == {STEP_W{1'b0}}) begin
      last_step_s = {STEP_W{1'b1}};
    end else begin
      last_step_s = step_len - STEP_W'(1);
    end
  end

  // Next-state logic; >= rather than == so a shrunken period or length never counts through the full range.
  always_comb begin
    cnt_d  = cnt_q;
    ap_d   = ap_q;
    step_d = step_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (restart) begin
      cnt_d  = {PERIOD_W{1'b0}};
      step_d = {STEP_W{1'b0}};
      clk_d  = 1'b0;
      ap_d   = period;
    end else begin
      case (state_s)
        RUN: begin
          if (cnt_q >= ap_q - PERIOD_W'(1)) begin
            tick_d = 1'b1;
            cnt_d  = {PERIOD_W{1'b0}};
            clk_d  = ~clk_q;
            ap_d   = period;
            if (step_q >= last_step_s) begin
              step_d = {STEP_W{1'b0}};
              wrap_d = 1'b1;
            end else begin
              step_d = step_q + STEP_W'(1);
            end
          end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
          end
        end
        STOP, HALT: ap_d = period;
        default:    ap_d = period;
      endcase
    end
  end

  // Channel state registers.
  always_ff @(posedge clk100hz) begin
    if (rst) begin
      cnt_q  <= {PERIOD_W{1'b0}};
      ap_q   <= {PERIOD_W{1'b0}};
      step_q <= {STEP_W{1'b0}};
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ap_q   <= ap_d;
      step_q <= step_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign tick    = tick_q;
  assign clk_out = clk_q;
  assign wrap    = wrap_q;
  assign step    = step_q;

endmodule

// File: rtl/var_clk_seq_multi.sv
// Multi-channel variable tempo sequencer: CHANNELS independent copies of var_clk_chan.
module var_clk_seq_multi
  import var_clk_seq_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int STEP_W   = STEP_W_DEF
) (
  input  logic                         clk100hz,
  input  logic                         rst,
  input  logic [CHANNELS*PERIOD_W-1:0] period,
  input  logic [CHANNELS-1:0]          enable,
  input  logic [CHANNELS*STEP_W-1:0]   step_len,
  input  logic                         restart,
  output logic [CHANNELS-1:0]          tick,
  output logic [CHANNELS-1:0]          clk_out,
  output logic [CHANNELS*STEP_W-1:0]   step,
  output logic [CHANNELS-1:0]          wrap
);

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_chan
      var_clk_chan #(
        .PERIOD_W (PERIOD_W),
        .STEP_W   (STEP_W)
      ) u_chan (
        .clk100hz (clk100hz),
        .rst      (rst),
        .enable   (enable[g]),
        .restart  (restart),
        .period   (period[g*PERIOD_W +: PERIOD_W]),
        .step_len (step_len[g*STEP_W +: STEP_W]),
        .tick     (tick[g]),
        .clk_out  (clk_out[g]),
        .wrap     (wrap[g]),
        .step     (step[g*STEP_W +: STEP_W])
      );
    end
  endgenerate

endmodule

// File: doc/var_clk_seq_multi.md
VAR_CLK_SEQ_MULTI -- requirements
Module: var_clk_seq_multi

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent tempo channels.
REQ-002 Parameter PERIOD_W, default 10: width of each channel period word, in clk100hz cycles.
REQ-003 Parameter STEP_W, default 4: width of each channel step counter and step length.
REQ-004 clk100hz  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 period  input  CHANNELS*PERIOD_W  per-channel half-period; channel n uses bits [n*PERIOD_W +: PERIOD_W].
REQ-007 enable  input  CHANNELS  per-channel run enable.
REQ-008 step_len  input  CHANNELS*STEP_W  per-channel sequence length; 0 means 2^STEP_W.
REQ-009 restart  input  1  synchronous re-phase pulse for all channels.
REQ-010 tick  output  CHANNELS  one-cycle strobe at each half-period boundary.
REQ-011 clk_out  output  CHANNELS  square wave, toggles on each tick, period 2*P cycles.
REQ-012 step  output  CHANNELS*STEP_W  current step index per channel.
REQ-013 wrap  output  CHANNELS  one-cycle strobe when step returns to 0.

Function
REQ-014 Each channel SHALL hold a counter cnt, an active period ap, and a state in {STOP, RUN, HALT}.
REQ-015 State selection: enable=0 -> STOP; enable=1 and ap=0 -> HALT; enable=1 and ap!=0 -> RUN.
REQ-016 In STOP and HALT, ap SHALL reload from period every cycle; cnt, step, clk_out SHALL hold; tick=0, wrap=0.
REQ-017 In RUN, cnt SHALL increment each cycle; when cnt == ap-1, tick=1 that cycle, cnt->0, clk_out toggles, ap reloads from period.
REQ-018 In RUN, period changes SHALL take effect only at the tick reload point; no mid-count truncation.
REQ-019 ap=1 SHALL produce tick every cycle and clk_out toggling every cycle.
REQ-020 First tick after enable rises from reset state SHALL occur exactly ap cycles after the first edge sampling enable=1.
REQ-021 On tick, step SHALL increment; if step == L-1 (L = step_len, or 2^STEP_W when 0), step->0 and wrap=1 same cycle as tick.
REQ-022 step_len reduced below current step SHALL cause wrap on the next tick (step->0), never counting through 2^STEP_W.
REQ-023 restart SHALL set cnt=0, step=0, clk_out=0, reload ap, in every channel; tick and wrap SHALL be 0 that cycle.
REQ-024 restart SHALL take priority over a coincident tick; enable=0 SHALL take priority over a coincident tick.
REQ-025 Channels SHALL be fully independent except for shared restart and rst.
REQ-026 tick, wrap, clk_out SHALL be registered outputs, no combinational path from inputs.

Reset
REQ-027 rst=1 SHALL set per channel: state=STOP, cnt=0, ap=0, step=0, clk_out=0, tick=0, wrap=0.
REQ-028 rst SHALL take priority over restart and enable; rst mid-count SHALL abort without a tick.
REQ-029 After rst deasserts, ap SHALL load from period on the first cycle.

Structure
REQ-030 Package var_clk_seq_pkg SHALL hold the state enum (STOP, RUN, HALT) and default PERIOD_W/STEP_W constants.
REQ-031 One sub-module var_clk_chan SHALL implement a single channel; top SHALL instantiate CHANNELS copies via generate.

Verification
REQ-032 rst, then enable[0]=1, period0=200 -> first tick at cycle 200, then every 200; clk_out0 period 400 cycles.
REQ-033 period0 changes 200->25 at cycle 50 of a count -> current interval remains 200, following intervals 25.
REQ-034 period0=0 with enable=1 -> HALT, no ticks over 103 cycles; period0=700 -> first tick 700 cycles later.
REQ-035 step_len0=4, period0=1 -> step 0,1,2,3,0; wrap high on the tick with step 3->0 only.
REQ-036 Channels 0..3 periods 3,5,7,0; restart pulsed coincident with channel-0 tick -> no tick, all counters and steps 0, ch3 silent.
REQ-037 rst asserted mid-count on ch1 -> all outputs 0 next cycle, no tick emitted.
